rhs_spi_responder: RTL
======================

Name: rhs_spi_responder

Overview:
- Synthesizable RHS2116-style SPI responder: the far end of the link driven by rhs_spi_master.
- Oversamples SCLK/MOSI/CS on the system clock and decodes 32-bit command frames.
- Maintains a small register bank and returns responses on MISO with the RHS2116 two-frame pipeline latency.
- Used as an on-FPGA loopback target for master bring-up and for hardware-in-loop checks of oversample_offset tuning.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on SCLK, MOSI and CS (min 2).
- NUM_REGS, 8, number of 16-bit registers in the bank (power of 2, max 256).

Ports:
- clk  input  1  system clock; must be at least 4x SCLK frequency.
- rst  input  1  synchronous, active-high reset.
- SCLK  input  1  SPI clock from master; CPOL=0.
- MOSI  input  1  command data from master; MSB first.
- CS  input  1  chip select, active low.
- MISO  output  1  response data to master; MSB first.
- frame_done  output  1  one-clk pulse when a valid 32-bit frame completes.
- frame_err  output  1  one-clk pulse when CS rises with a bit count other than 32.
- last_cmd  output  32  last valid command word received.
- frame_count  output  16  count of valid frames; wraps 16'hFFFF to 0.

Behaviour:
- Reset (rst=1 at a clk edge) clears all state:
  - MISO=0, frame_done=0, frame_err=0, last_cmd=0, frame_count=0.
  - All registers = 0; both pipeline stages = 32'h0; bit counter = 0.
- Input path:
  - SCLK, MOSI and CS each pass through SYNC_STAGES flops, then one more delay flop for edge detection.
  - Rise and fall are detected on the synchronized signals only.
- SPI mode 0:
  - MOSI is sampled on each synchronized SCLK rise while CS is low.
  - MISO changes on each synchronized SCLK fall while CS is low.
- Frame start (CS falling):
  - Bit counter clears.
  - Shift-out register loads pipeline stage 2, and MISO drives its bit 31 on the next clk.
- Data phase:
  - Each SCLK rise shifts MOSI into the shift-in register and increments the bit counter (saturates at 63).
  - Each SCLK fall after at least one rise shifts the shift-out register left, and MISO drives the new MSB.
  - MISO lags the SCLK falling edge by SYNC_STAGES+2 clk cycles; the master compensates with oversample_offset.
- CS high: MISO=0; SCLK edges are ignored.
- Frame end (CS rising), bit count == 32:
  - Decode the command.
  - Stage 2 <= stage 1; stage 1 <= new response.
  - last_cmd <= command; frame_count increments.
  - frame_done pulses one clk later.
- Frame end, bit count != 32 (including 0):
  - No decode, no pipeline or register change.
  - frame_err pulses one clk later.
- Command decode, cmd[31:30]:
  - 00 CONVERT: ch = cmd[21:16]; response = {2'b00, ch, 8'h00, ch, frame_count[9:0]}, using frame_count before the increment.
  - 01 CLEAR: response = 32'h0000_0000.
  - 10 WRITE: addr = cmd[23:16]. If addr < NUM_REGS, reg[addr] <= cmd[15:0]; otherwise ignored. Response = {16'hFFFF, cmd[15:0]}.
  - 11 READ: addr = cmd[23:16]. Response = {16'h0000, reg[addr]} if addr < NUM_REGS, otherwise 32'h0. A READ of an address written in the same frame returns the old value.
- Latency: the response to frame N appears on MISO during frame N+2. Frames N and N+1 return earlier responses, or zeros after reset.
- Simultaneous events:
  - A CS rise and an SCLK edge detected in the same clk: the CS rise wins and the SCLK edge is dropped.
  - rst asserted mid-frame: the frame is abandoned with no frame_err. After reset, the first frame starts at the next CS fall; a CS that is already low at reset release is ignored until it rises.

Test Plan:
- Three frames WRITE 32'h8003_BEEF, READ 32'hC003_0000, CLEAR 32'h4000_0000:
  - Frame 3 MISO = 32'hFFFF_BEEF.
  - A fourth frame (any command) returns 32'h0000_BEEF.
  - frame_count = 4.
- Immediately after reset, two CONVERT frames with ch=31:
  - Both return 32'h0.
  - The third frame returns 32'h1F00_7C00 (ch=31, frame_count=0).
- Pull CS high after 20 SCLK rises:
  - frame_err pulses once; frame_count is unchanged.
  - The next valid frame returns the same response the aborted frame would have.
- WRITE to addr 8 (32'h8008_1234), then READ addr 8:
  - WRITE response = 32'hFFFF_1234.
  - READ response = 32'h0.
  - reg[0..7] are unchanged.
- Assert rst mid-frame at bit 16:
  - MISO=0 and pipeline is zero; no frame_err.
  - The next frame returns 32'h0 and last_cmd = 0 until a valid frame completes.
- Drive from rhs_spi_master at 112 MHz clk with oversample_offset=3 and 32'hDEADBEEF (READ, addr 0xAD):
  - The master captures 32'h0 two frames later.
  - Sweeping the offset locates a valid capture window consistent with the SYNC_STAGES+2 MISO lag.

Source files
------------

// File: rtl/rhs_spi_responder.sv
// RHS2116-style SPI responder (mode 0). SCLK/MOSI/CS are oversampled on clk,
// 32-bit command frames are decoded, and responses come back on MISO two
// frames later through a two-stage response pipeline.
module rhs_spi_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_REGS    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SCLK,
   input  logic        MOSI,
   input  logic        CS,
   output logic        MISO,
   output logic        frame_done,
   output logic        frame_err,
   output logic [31:0] last_cmd,
   output logic [15:0] frame_count
);

   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
   logic                   sclk_d, cs_d;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

   logic [15:0] reg_bank [NUM_REGS];
   logic [31:0] shift_in, shift_out;
   logic [31:0] stage1, stage2;
   logic [5:0]  bit_cnt;
   logic        in_frame;

   logic [7:0]  addr;
   logic        addr_ok;
   logic [15:0] rd_data;
   logic [5:0]  ch;
   logic [31:0] response;

   // Synchronizer chains plus one delay flop for edge detection.
   // Chains reset low so a CS already low at reset release never looks like a fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_sync   <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         cs_d      <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   assign addr    = shift_in[23:16];
   assign addr_ok = {1'b0, addr} < NUM_REGS_W;
   assign rd_data = reg_bank[addr[AW-1:0]];
   assign ch      = shift_in[21:16];

   // Response for the command currently held in the shift-in register.
   always_comb begin
      response = 32'h0;
      case (shift_in[31:30])
         2'b00:   response = {2'b00, ch, 8'h00, ch, frame_count[9:0]};
         2'b01:   response = 32'h0;
         2'b10:   response = {16'hFFFF, shift_in[15:0]};
         default: response = addr_ok ? {16'h0000, rd_data} : 32'h0;
      endcase
   end

   // Frame sequencing, shifting, decode and response pipeline.
   // A CS rise takes priority over any SCLK edge seen in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         MISO        <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         last_cmd    <= 32'h0;
         frame_count <= 16'h0;
         shift_in    <= 32'h0;
         shift_out   <= 32'h0;
         stage1      <= 32'h0;
         stage2      <= 32'h0;
         bit_cnt     <= 6'd0;
         in_frame    <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) reg_bank[i] <= 16'h0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (cs_fall) begin
            in_frame  <= 1'b1;
            bit_cnt   <= 6'd0;
            shift_out <= stage2;
         end else if (in_frame && cs_rise) begin
            in_frame <= 1'b0;
            if (bit_cnt == 6'd32) begin
               stage2      <= stage1;
               stage1      <= response;
               last_cmd    <= shift_in;
               frame_count <= frame_count + 16'd1;
               frame_done  <= 1'b1;
               if (shift_in[31:30] == 2'b10 && addr_ok)
                  reg_bank[addr[AW-1:0]] <= shift_in[15:0];
            end else begin
               frame_err <= 1'b1;
            end
         end else if (in_frame) begin
            if (sclk_rise) begin
               shift_in <= {shift_in[30:0], mosi_s};
               if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
            end else if (sclk_fall && bit_cnt != 6'd0) begin
               shift_out <= {shift_out[30:0], 1'b0};
            end
         end
         MISO <= in_frame ? shift_out[31] : 1'b0;
      end
   end

endmodule
